oam_scan_sequencer: RTL
=======================

Name: oam_scan_sequencer

Overview:
Per-scanline OAM walker that sits directly upstream of the object lookup/attribute pipeline. On each line-start pulse it reads all 128 OAM entries for the next row (vcount+1), rejects disabled, prohibited-shape and non-intersecting objects, and streams surviving attribute triples downstream over a valid/ready handshake. It also reports when the scan is finished and how many objects were emitted.

Parameters:
OAM_BASE, 32'h0700_0000, byte address of OAM entry 0; entry i word0 is at OAM_BASE+8*i and word1 at OAM_BASE+8*i+4.
MAX_OBJS, 128, maximum number of objects emitted per line (1..128). The scan ends early once this cap is reached.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
line_start  input  1  one-cycle pulse that starts a scan for row vcount+1
obj_enable  input  1  DISPCNT object enable, sampled on line_start
vcount  input  8  current line 0..227, sampled on line_start
OAM_mem_addr  output  32  OAM byte address; registered
OAM_mem_data  input  32  read data, valid exactly one cycle after the address is presented
obj_valid  output  1  descriptor valid
obj_ready  input  1  downstream accept
obj_attr0  output  16  attr0 of the emitted object
obj_attr1  output  16  attr1 of the emitted object
obj_attr2  output  16  attr2 of the emitted object
obj_index  output  7  OAM index of the emitted object
scan_done  output  1  one-cycle pulse when the scan completes
obj_count  output  8  number of objects emitted in the last/current scan

Behaviour:
- Reset:
  - state IDLE.
  - OAM_mem_addr=OAM_BASE.
  - obj_valid=0, obj_attr0/1/2=0, obj_index=0, scan_done=0, obj_count=0.
  - Reset mid-scan abandons the scan and raises no done pulse.
- Row computation: row = (vcount==227) ? 0 : vcount+1, latched on line_start.
- Word layout:
  - word0: attr0 in [15:0], attr1 in [31:16].
  - word1: attr2 in [15:0]; [31:16] is ignored.
- Reject rules:
  - Disabled: attr0[8]=0 and attr0[9]=1.
  - Prohibited shape: attr0[15:14]=3.
- Height H from shape attr0[15:14] and size attr1[15:14]:
  - square: 8, 16, 32, 64
  - horizontal: 8, 8, 16, 32
  - vertical: 16, 32, 32, 64
  - H is doubled when attr0[8]=1 and attr0[9]=1.
- Visibility: visible iff ((row - attr0[7:0]) mod 256) < H, using 8-bit wrap subtraction so that y near 255 wraps to the top of the screen.
- FSM states: IDLE, READ0, READ1, CHECK, EMIT, DONE.
  - IDLE, line_start, obj_enable=1: clear index and obj_count, go to READ0.
  - IDLE, line_start, obj_enable=0: go to DONE with obj_count=0.
  - READ0: drive OAM_mem_addr = OAM_BASE + 8*index; go to READ1.
  - READ1: latch attr0/attr1 from data; drive address +4; go to CHECK.
  - CHECK: latch attr2; evaluate the reject and visibility rules.
    - Pass: go to EMIT.
    - Fail: go to NEXT (see below).
  - EMIT: obj_valid=1 and outputs held stable until obj_ready=1.
    - On the handshake cycle: obj_count+1, then NEXT.
  - NEXT (an action, not a state):
    - If index==127 or obj_count==MAX_OBJS: go to DONE.
    - Otherwise index+1 and go to READ0.
  - DONE: scan_done=1 for one cycle; return to IDLE.
- Timing with obj_ready held high: a visible object costs 4 cycles and a rejected object costs 3 cycles.
- obj_valid never drops without a handshake, except on reset or restart.
- line_start outside IDLE: immediate restart. obj_valid drops, no scan_done is raised, a new row is latched, and the scan restarts at index 0.
- obj_count holds its final value until the next line_start.

Optional Feature:
Macro OAM_SCAN_EARLY_REJECT_EN.
- Defined: the reject and visibility rules are evaluated in READ1 directly on OAM_mem_data. A rejected object goes straight to NEXT without reading word1, so it costs 2 cycles.
- Undefined: every object reads both words (3 cycles per rejected object).
- Emitted descriptors and emission order are identical in both builds.

Test Plan:
- Reset, then idle 10 cycles -> obj_valid=0, scan_done=0, obj_count=0, OAM_mem_addr=32'h0700_0000.
- OAM all entries disabled (attr0=16'h0200); line_start with vcount=10 -> no obj_valid; scan_done after 128×3 cycles (128×2 with the macro defined); obj_count=0.
- Entry 5: attr0=16'h0014 (y=20, square), attr1=16'h4000 (16×16), attr2=16'h1234; vcount=27 -> row 28, one emit with obj_index=5, attr2=16'h1234, obj_count=1. With vcount=35 (row 36) -> no emit.
- Wrap case: entry 0 with y=250, 16-tall object; vcount=3 -> row 4, emitted. Separately, vcount=227 -> row 0, also emitted.
- Backpressure: two visible objects, obj_ready=0 for 20 cycles -> obj_valid high with attributes stable throughout; release obj_ready -> both accepted in order; obj_count=2.
- MAX_OBJS=4 with 10 visible objects -> exactly 4 emits, then scan_done. Separately, a line_start issued mid-EMIT -> obj_valid drops next cycle, no scan_done, and the scan restarts at index 0.

Source files
------------

// File: rtl/oam_scan_sequencer_if.sv
// ----------------------------------------------------------------------------
// oam_scan_sequencer_if
// Groups the two buses of the OAM scan sequencer:
//   - OAM read port  : OAM_mem_addr (byte address, from sequencer),
//                      OAM_mem_data (read data, one cycle after the address)
//   - object stream  : obj_valid / obj_ready handshake carrying
//                      obj_attr0/1/2 and obj_index of each visible object
// Modports:
//   master - the sequencer side (drives address and descriptor stream)
//   slave  - the OAM memory plus downstream object pipeline side
// ----------------------------------------------------------------------------
interface oam_scan_sequencer_if;
    logic [31:0] OAM_mem_addr;
    logic [31:0] OAM_mem_data;
    logic        obj_valid;
    logic        obj_ready;
    logic [15:0] obj_attr0;
    logic [15:0] obj_attr1;
    logic [15:0] obj_attr2;
    logic [6:0]  obj_index;

    modport master (
        output OAM_mem_addr,
        input  OAM_mem_data,
        output obj_valid,
        input  obj_ready,
        output obj_attr0,
        output obj_attr1,
        output obj_attr2,
        output obj_index
    );

    modport slave (
        input  OAM_mem_addr,
        output OAM_mem_data,
        input  obj_valid,
        output obj_ready,
        input  obj_attr0,
        input  obj_attr1,
        input  obj_attr2,
        input  obj_index
    );
endinterface

// File: rtl/oam_scan_sequencer.sv
// ----------------------------------------------------------------------------
// oam_scan_sequencer
// Per-scanline OAM walker. On line_start it latches the next row
// (vcount+1, wrapping 227 -> 0), reads the two words of each of the 128 OAM
// entries, drops disabled / prohibited-shape / non-intersecting objects and
// streams the surviving attribute triples downstream on a valid/ready
// handshake. scan_done pulses once when the walk finishes and obj_count
// holds the number of emitted objects until the next line_start.
//
// Ports:
//   clock, reset      - clock and synchronous active-high reset
//   line_start        - one-cycle pulse, starts (or restarts) a scan
//   obj_enable        - object layer enable, sampled on line_start
//   vcount[7:0]       - current line, sampled on line_start
//   bus (master)      - OAM read port and object descriptor stream
//   scan_done         - one-cycle completion pulse (registered)
//   obj_count[7:0]    - objects emitted in the last/current scan (registered)
//
// Build option:
//   OAM_SCAN_EARLY_REJECT_EN - when defined, reject and visibility rules are
//   evaluated on word0 as it arrives, so rejected entries skip the word1
//   read (2 cycles per rejected entry instead of 3).
// ----------------------------------------------------------------------------
module oam_scan_sequencer #(
    parameter logic [31:0] OAM_BASE = 32'h0700_0000,
    parameter int unsigned MAX_OBJS = 128
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        line_start,
    input  logic                        obj_enable,
    input  logic [7:0]                  vcount,
    oam_scan_sequencer_if.master        bus,
    output logic                        scan_done,
    output logic [7:0]                  obj_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ0 = 3'd1,
        READ1 = 3'd2,
        CHECK = 3'd3,
        EMIT  = 3'd4,
        DONE  = 3'd5
    } state_e;

    localparam logic [7:0] MAX_OBJS_C = 8'(MAX_OBJS);

    // Object height in lines from shape/size, doubled for double-size affine
    // objects. Prohibited shape returns 0 so nothing can intersect.
    function automatic logic [7:0] obj_height(input logic [15:0] a0,
                                              input logic [15:0] a1);
        logic [7:0] h;
        case ({a0[15:14], a1[15:14]})
            4'b00_00: h = 8'd8;
            4'b00_01: h = 8'd16;
            4'b00_10: h = 8'd32;
            4'b00_11: h = 8'd64;
            4'b01_00: h = 8'd8;
            4'b01_01: h = 8'd8;
            4'b01_10: h = 8'd16;
            4'b01_11: h = 8'd32;
            4'b10_00: h = 8'd16;
            4'b10_01: h = 8'd32;
            4'b10_10: h = 8'd32;
            4'b10_11: h = 8'd64;
            default:  h = 8'd0;
        endcase
        if (a0[8] && a0[9]) begin
            h = {h[6:0], 1'b0};
        end else begin
            h = h;
        end
        return h;
    endfunction

    // True when the entry is enabled, has a legal shape and covers the row.
    // The 8-bit subtraction wraps so objects with y near 255 reach row 0+.
    function automatic logic obj_accept(input logic [15:0] a0,
                                        input logic [15:0] a1,
                                        input logic [7:0]  row);
        logic       disabled;
        logic       prohibited;
        logic [7:0] dy;
        disabled   = (a0[8] == 1'b0) && (a0[9] == 1'b1);
        prohibited = (a0[15:14] == 2'b11);
        dy         = row - a0[7:0];
        return !disabled && !prohibited && (dy < obj_height(a0, a1));
    endfunction

    state_e      state_q, state_d;
    logic [7:0]  row_q, row_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] attr0_q, attr0_d;
    logic [15:0] attr1_q, attr1_d;
    logic [15:0] attr2_q, attr2_d;
    logic [6:0]  index_q, index_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;
    logic [7:0]  count_q, count_d;
    logic        advance_s;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        addr_d    = addr_q;
        attr0_d   = attr0_q;
        attr1_d   = attr1_q;
        attr2_d   = attr2_q;
        index_d   = index_q;
        valid_d   = valid_q;
        count_d   = count_q;
        done_d    = 1'b0;
        advance_s = 1'b0;

        // The address register is loaded on entry to each read state so the
        // address is on the bus during that state and its data arrives in
        // the following one.
        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            READ0: begin
                addr_d  = addr_q + 32'd4;
                state_d = READ1;
            end
            READ1: begin
                attr0_d = bus.OAM_mem_data[15:0];
                attr1_d = bus.OAM_mem_data[31:16];
`ifdef OAM_SCAN_EARLY_REJECT_EN
                if (obj_accept(bus.OAM_mem_data[15:0], bus.OAM_mem_data[31:16], row_q)) begin
                    state_d = CHECK;
                end else begin
                    advance_s = 1'b1;
                end
`else
                state_d = CHECK;
`endif
            end
            CHECK: begin
                attr2_d = bus.OAM_mem_data[15:0];
`ifdef OAM_SCAN_EARLY_REJECT_EN
                state_d = EMIT;
                valid_d = 1'b1;
`else
                if (obj_accept(attr0_q, attr1_q, row_q)) begin
                    state_d = EMIT;
                    valid_d = 1'b1;
                end else begin
                    advance_s = 1'b1;
                end
`endif
            end
            EMIT: begin
                if (bus.obj_ready) begin
                    valid_d   = 1'b0;
                    count_d   = count_q + 8'd1;
                    advance_s = 1'b1;
                end else begin
                    valid_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Step to the next entry, or finish on the last entry / object cap.
        // count_d already includes a handshake taken this cycle.
        if (advance_s) begin
            if ((index_q == 7'd127) || (count_d == MAX_OBJS_C)) begin
                state_d = DONE;
            end else begin
                index_d = index_q + 7'd1;
                addr_d  = OAM_BASE + {22'd0, index_d, 3'b000};
                state_d = READ0;
            end
        end else begin
            index_d = index_d;
        end

        // line_start wins in every state: a scan in flight is abandoned
        // without a done pulse and a fresh one starts at entry 0.
        if (line_start) begin
            row_d   = (vcount == 8'd227) ? 8'd0 : vcount + 8'd1;
            index_d = 7'd0;
            count_d = 8'd0;
            valid_d = 1'b0;
            addr_d  = OAM_BASE;
            if (obj_enable) begin
                state_d = READ0;
            end else begin
                state_d = DONE;
            end
        end else begin
            row_d = row_d;
        end

        done_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            row_q   <= 8'd0;
            addr_q  <= OAM_BASE;
            attr0_q <= 16'd0;
            attr1_q <= 16'd0;
            attr2_q <= 16'd0;
            index_q <= 7'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            attr0_q <= attr0_d;
            attr1_q <= attr1_d;
            attr2_q <= attr2_d;
            index_q <= index_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign bus.OAM_mem_addr = addr_q;
    assign bus.obj_valid    = valid_q;
    assign bus.obj_attr0    = attr0_q;
    assign bus.obj_attr1    = attr1_q;
    assign bus.obj_attr2    = attr2_q;
    assign bus.obj_index    = index_q;
    assign scan_done        = done_q;
    assign obj_count        = count_q;

endmodule
